// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet buffer: beats are held until their packet's last beat is stored,
// so only complete packets are re-emitted. Packets longer than DEPTH beats are dropped whole.
module stream_packet_fifo #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int T_ID_WIDTH   = 1,
    parameter int DEPTH        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [T_DATA_WIDTH-1:0]    s_data_i,
    input  logic [T_QOS_WIDTH-1:0]     s_qos_i,
    input  logic [T_ID_WIDTH-1:0]      s_id_i,
    input  logic                       s_last_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic [T_DATA_WIDTH-1:0]    m_data_o,
    output logic [T_QOS_WIDTH-1:0]     m_qos_o,
    output logic [T_ID_WIDTH-1:0]      m_id_o,
    output logic                       m_last_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [$clog2(DEPTH):0]     pkt_count_o,
    output logic                       drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = T_DATA_WIDTH + T_QOS_WIDTH + T_ID_WIDTH + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   pkt_start_q, pkt_start_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   pkt_count_q, pkt_count_d;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   rd_word;
    logic            rd_last;

    logic            oversize;
    logic            wr_en;
    logic            rd_en;
    logic            commit;
    logic            consume;

    // The whole array is one incomplete packet: it can never be committed.
    assign oversize = (level_q == FULL_LEVEL) && (pkt_count_q == '0);

    assign rd_word   = mem[rd_ptr_q];
    assign rd_last   = rd_word[0];
    assign m_valid_o = (pkt_count_q != '0);
    assign m_data_o  = m_valid_o ? rd_word[EW-1 -: T_DATA_WIDTH] : '0;
    assign m_qos_o   = m_valid_o ? rd_word[T_ID_WIDTH+T_QOS_WIDTH : T_ID_WIDTH+1] : '0;
    assign m_id_o    = m_valid_o ? rd_word[T_ID_WIDTH:1] : '0;
    assign m_last_o  = m_valid_o & rd_last;

    assign level_o     = level_q;
    assign pkt_count_o = pkt_count_q;

    assign wr_en   = (state_q == FILL) && s_valid_i && s_ready_o;
    assign rd_en   = m_valid_o && m_ready_i;
    assign commit  = wr_en && s_last_i;
    assign consume = rd_en && rd_last;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {s_data_i, s_qos_i, s_id_i, s_last_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_start_q <= '0;
            level_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_start_q <= pkt_start_d;
            level_q     <= level_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_start_d = pkt_start_q;
        level_d     = level_q;
        pkt_count_d = pkt_count_q;
        s_ready_o   = 1'b1;
        drop_o      = 1'b0;

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case ({commit, consume})
            2'b10:   pkt_count_d = pkt_count_q + LW'(1);
            2'b01:   pkt_count_d = pkt_count_q - LW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (commit) begin
            pkt_start_d = wr_ptr_q + AW'(1);
        end

        case (state_q)
            FILL: begin
                s_ready_o = (level_q != FULL_LEVEL);
                if (oversize) begin
                    // No committed packets exist, so rewinding empties the array.
                    drop_o   = 1'b1;
                    state_d  = DROP;
                    wr_ptr_d = pkt_start_q;
                    level_d  = '0;
                end
            end
            DROP: begin
                s_ready_o = 1'b1;
                if (s_valid_i && s_last_i) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Directed bench for stream_packet_fifo: a scoreboard queue is filled as beats are driven
// and drained by an output monitor; state checks are immediate assertions.
module tb_stream_packet_fifo;

    localparam int DW = 8;
    localparam int QW = 4;
    localparam int IW = 1;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data_i;
    logic [QW-1:0] s_qos_i;
    logic [IW-1:0] s_id_i;
    logic          s_last_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] m_data_o;
    logic [QW-1:0] m_qos_o;
    logic [IW-1:0] m_id_o;
    logic          m_last_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [LW-1:0] level_o;
    logic [LW-1:0] pkt_count_o;
    logic          drop_o;

    int errors = 0;
    int checks = 0;
    int drop_cnt = 0;
    int out_cnt = 0;
    logic [13:0] exp_q[$];

    stream_packet_fifo #(
        .T_DATA_WIDTH(DW), .T_QOS_WIDTH(QW), .T_ID_WIDTH(IW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_id_i(s_id_i), .s_last_i(s_last_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .level_o(level_o), .pkt_count_o(pkt_count_o), .drop_o(drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every consumed beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop_o) drop_cnt++;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'({m_data_o, m_qos_o, m_id_o, m_last_o}), 32'hDEAD_BEEF);
                end else begin
                    check("out_beat", 32'({m_data_o, m_qos_o, m_id_o, m_last_o}), 32'(exp_q.pop_front()));
                end
                $display("out beat %0d: data=%0h qos=%0h id=%0d last=%0d", out_cnt, m_data_o, m_qos_o, m_id_o, m_last_o);
                out_cnt++;
            end else if (!m_valid_o) begin
                check("idle_zero", 32'({m_data_o, m_qos_o, m_id_o, m_last_o}), 32'h0);
            end
        end
    end

    // Drives one beat and waits for acceptance; pushes it if it should come out.
    task automatic send_beat(input logic [DW-1:0] d, input logic [QW-1:0] q, input logic [IW-1:0] id,
                             input logic last, input bit pass);
        bit acc;
        int n;
        s_data_i = d; s_qos_i = q; s_id_i = id; s_last_i = last; s_valid_i = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'(1));
        else if (pass) exp_q.push_back({d, q, id, last});
        s_valid_i = 1'b0;
        s_last_i = 1'b0;
        $display("in beat: data=%0h qos=%0h id=%0d last=%0d accepted=%0d", d, q, id, last, acc);
    endtask

    task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [QW-1:0] q,
                            input logic [IW-1:0] id, input bit pass);
        for (int i = 0; i < len; i++) begin
            send_beat(base + DW'(i), q, id, (i == len - 1), pass);
        end
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || level_o != '0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(level_o), 32'(0));
        check({tag, "_sb"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        s_data_i = '0; s_qos_i = '0; s_id_i = '0; s_last_i = 1'b0; s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        #1;
        check("rst_level", 32'(level_o), 32'(0));
        check("rst_pkt_count", 32'(pkt_count_o), 32'(0));
        check("rst_s_ready", 32'(s_ready_o), 32'(1));
        check("rst_m_valid", 32'(m_valid_o), 32'(0));
        check("rst_drop", 32'(drop_o), 32'(0));
        check("rst_m_out", 32'({m_data_o, m_qos_o, m_id_o, m_last_o}), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // T1: 3-beat packet, output valid only after the last beat is stored
        m_ready_i = 1'b1;
        send_beat(8'hA0, 4'd5, 1'b1, 1'b0, 1'b1);
        send_beat(8'hA1, 4'd5, 1'b1, 1'b0, 1'b1);
        check("t1_no_valid_partial", 32'(m_valid_o), 32'(0));
        check("t1_level_partial", 32'(level_o), 32'(2));
        send_beat(8'hA2, 4'd5, 1'b1, 1'b1, 1'b1);
        check("t1_valid_after_last", 32'(m_valid_o), 32'(1));
        check("t1_first_data", 32'(m_data_o), 32'(8'hA0));
        wait_drained("t1_drained");

        // T2: two packets held, then streamed without gaps
        m_ready_i = 1'b0;
        send_pkt(2, 8'h10, 4'd3, 1'b0, 1'b1);
        send_pkt(3, 8'h20, 4'd9, 1'b1, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("t2_pkt_count", 32'(pkt_count_o), 32'(2));
        check("t2_level", 32'(level_o), 32'(5));
        check("t2_stable_data", 32'(m_data_o), 32'(8'h10));
        m_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_no_gap", 32'(m_valid_o), 32'(1));
        end
        wait_drained("t2_drained");

        // T3: full with a committed packet -> back-pressure, no drop
        m_ready_i = 1'b0;
        d0 = drop_cnt;
        send_pkt(15, 8'h30, 4'd1, 1'b0, 1'b1);
        fork
            send_pkt(3, 8'h50, 4'd2, 1'b1, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                check("t3_level_full", 32'(level_o), 32'(16));
                check("t3_s_ready_low", 32'(s_ready_o), 32'(0));
                check("t3_pkt_count", 32'(pkt_count_o), 32'(1));
                m_ready_i = 1'b1;
            end
        join
        wait_drained("t3_drained");
        check("t3_no_drop", 32'(drop_cnt - d0), 32'(0));

        // T4: 20-beat packet is dropped whole, next packet passes
        m_ready_i = 1'b1;
        d0 = drop_cnt;
        for (int i = 0; i < 16; i++) send_beat(8'h60 + 8'(i), 4'd7, 1'b0, 1'b0, 1'b0);
        check("t4_drop_pulse", 32'(drop_o), 32'(1));
        check("t4_s_ready_oversize", 32'(s_ready_o), 32'(0));
        send_beat(8'h70, 4'd7, 1'b0, 1'b0, 1'b0);
        check("t4_level_after_drop", 32'(level_o), 32'(0));
        send_beat(8'h71, 4'd7, 1'b0, 1'b0, 1'b0);
        send_beat(8'h72, 4'd7, 1'b0, 1'b0, 1'b0);
        send_beat(8'h73, 4'd7, 1'b0, 1'b1, 1'b0);
        check("t4_no_valid", 32'(m_valid_o), 32'(0));
        check("t4_drop_once", 32'(drop_cnt - d0), 32'(1));
        send_pkt(2, 8'h80, 4'd4, 1'b1, 1'b1);
        wait_drained("t4_drained");

        // T5: exactly DEPTH beats is legal
        m_ready_i = 1'b0;
        d0 = drop_cnt;
        send_pkt(16, 8'h90, 4'd6, 1'b1, 1'b1);
        #1;
        check("t5_level", 32'(level_o), 32'(16));
        check("t5_pkt_count", 32'(pkt_count_o), 32'(1));
        check("t5_drop_low", 32'(drop_o), 32'(0));
        m_ready_i = 1'b1;
        wait_drained("t5_drained");
        check("t5_no_drop", 32'(drop_cnt - d0), 32'(0));

        // T6: asynchronous reset mid-packet with a committed packet stored
        m_ready_i = 1'b0;
        send_pkt(2, 8'hB0, 4'd2, 1'b0, 1'b1);
        send_beat(8'hC0, 4'd2, 1'b1, 1'b0, 1'b0);
        send_beat(8'hC1, 4'd2, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(m_valid_o), 32'(0));
        check("t6_level_async", 32'(level_o), 32'(0));
        check("t6_pkt_count_async", 32'(pkt_count_o), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_ready_i = 1'b1;
        send_pkt(3, 8'hD0, 4'd8, 1'b0, 1'b1);
        wait_drained("t6_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
